// File: rtl/muldiv_sequencer.sv
// Multicycle signed multiply/divide (shift-add / restoring) with its own FSM; `MULDIV_UNSIGNED_EN adds multu/divu.
// Latency: LOAD 1 cycle, CALC WIDTH cycles, done in cycle WIDTH+2 after start; divide-by-zero flagged in cycle 2.
// Backpressure: start is honoured only while idle; requests while busy are dropped, not queued.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic             highwrite,
  output logic             lowwrite,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, RESULT, DIVZ} state_t;

  state_t             state, state_nxt;
  logic               op_q, uns_q, neg_q, neg_r, uns_in, last_iter;
  logic [WIDTH-1:0]   a_q, b_q, a_abs, b_abs, res_hi, res_lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] p, p_step, prod;
  logic [WIDTH:0]     add_sum, rem_sh, diff;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (op_q && (b_q == '0)) ? DIVZ : CALC;
      CALC:    if (last_iter) state_nxt = RESULT;
      RESULT:  state_nxt = IDLE;
      DIVZ:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p holds {partial product} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    a_abs   = (!uns_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs   = (!uns_q && b_q[WIDTH-1]) ? -b_q : b_q;
    add_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_q} : '0);
    rem_sh  = p[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, b_q};
    if (!op_q)
      p_step = {add_sum, p[WIDTH-1:1]};
    else if (diff[WIDTH])
      p_step = {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    else
      p_step = {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    prod = neg_q ? -p_step : p_step;
    if (op_q) begin
      res_lo = neg_q ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
      res_hi = neg_r ? -p_step[2*WIDTH-1:WIDTH] : p_step[2*WIDTH-1:WIDTH];
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 1'b0;
      uns_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      p         <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divzero   <= 1'b0;
      highwrite <= 1'b0;
      lowwrite  <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == RESULT);
      highwrite <= (state_nxt == RESULT);
      lowwrite  <= (state_nxt == RESULT);
      divzero   <= (state_nxt == DIVZ);
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          uns_q <= uns_in;
          a_q   <= a_in;
          b_q   <= b_in;
        end
        LOAD: begin
          a_q   <= a_abs;
          b_q   <= b_abs;
          neg_q <= !uns_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= !uns_q && a_q[WIDTH-1];
          cnt   <= '0;
          p     <= {{WIDTH{1'b0}}, (op_q ? a_abs : b_abs)};
        end
        CALC: begin
          p   <= p_step;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi_out <= res_hi;
            lo_out <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, interruption sequences, random ops vs arithmetic model.
module tb_muldiv_sequencer;

  logic        clk, reset, start, op, uns;
  logic [31:0] a_in, b_in, hi_out, lo_out;
  logic        busy, done, divzero, highwrite, lowwrite;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in),
`ifdef MULDIV_UNSIGNED_EN
    .is_unsigned(uns),
`endif
    .busy(busy), .done(done), .divzero(divzero),
    .highwrite(highwrite), .lowwrite(lowwrite),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        o;
    logic        u;
    logic [31:0] a;
    logic [31:0] b;
    logic        dz;
    logic [63:0] res;   // {hi, lo}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}
  function automatic logic [63:0] model(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!o) begin
      if (u) m = ua * ub;
      else   m = sa * sb;
    end else if (b == 32'd0) begin
      m = 64'd0;
    end else if (u) begin
      uq = ua / ub;
      ur = ua % ub;
      m = {ur[31:0], uq[31:0]};
    end else begin
      q = sa / sb;
      r = sa % sb;
      m = {r[31:0], q[31:0]};
    end
    return m;
  endfunction

  // Runs one op starting at the current negedge (= cycle 0) and checks every cycle.
  task automatic run(input string nm, input logic o, input logic u, input logic [31:0] a,
                     input logic [31:0] b, input logic dz, input logic [63:0] res,
                     input int poke_cyc, input int rst_cyc);
    int last, done_cnt, done_cyc, dz_cnt, dz_cyc, busy_err, strb_err, hold_err;
    logic aborted, e_busy;
    logic [31:0] e_hi, e_lo, got_hi, got_lo;
    last = (rst_cyc > 0) ? rst_cyc + 1 : (dz ? 6 : 38);
    done_cnt = 0; done_cyc = -1; dz_cnt = 0; dz_cyc = -1;
    busy_err = 0; strb_err = 0; hold_err = 0;
    got_hi = 32'd0; got_lo = 32'd0;
    op = o; uns = u; a_in = a; b_in = b; start = 1'b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      aborted = (rst_cyc > 0) && (cyc > rst_cyc);
      if (aborted) begin
        e_busy = 1'b0; e_hi = 32'd0; e_lo = 32'd0;
      end else if (dz) begin
        e_busy = (cyc <= 2); e_hi = res[63:32]; e_lo = res[31:0];
      end else begin
        e_busy = (cyc <= 34);
        e_hi = (cyc >= 34) ? res[63:32] : prev_hi;
        e_lo = (cyc >= 34) ? res[31:0]  : prev_lo;
      end
      if (busy !== e_busy) busy_err++;
      if (hi_out !== e_hi || lo_out !== e_lo) hold_err++;
      if (highwrite !== done || lowwrite !== done) strb_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        got_hi = hi_out; got_lo = lo_out;
      end
      if (divzero === 1'b1) begin
        dz_cnt++;
        if (dz_cyc < 0) dz_cyc = cyc;
      end
      // operands wander after cycle 0; an optional stray start is injected
      start = (cyc == poke_cyc);
      op    = 1'($urandom);
      a_in  = $urandom;
      b_in  = $urandom;
      reset = (cyc == rst_cyc);
    end
    start = 1'b0;
    if (rst_cyc > 0) begin
      check({nm, "_abort_no_done"}, 64'(done_cnt), 64'd0);
      check({nm, "_abort_no_divzero"}, 64'(dz_cnt), 64'd0);
      prev_hi = 32'd0; prev_lo = 32'd0;
    end else if (dz) begin
      check({nm, "_divzero_count"}, 64'(dz_cnt), 64'd1);
      check({nm, "_divzero_cycle"}, 64'(dz_cyc), 64'd2);
      check({nm, "_no_done"}, 64'(done_cnt), 64'd0);
      check({nm, "_hi_lo_kept"}, {hi_out, lo_out}, res);
    end else begin
      check({nm, "_done_count"}, 64'(done_cnt), 64'd1);
      check({nm, "_done_cycle"}, 64'(done_cyc), 64'd34);
      check({nm, "_no_divzero"}, 64'(dz_cnt), 64'd0);
      check({nm, "_hi"}, {32'd0, got_hi}, {32'd0, res[63:32]});
      check({nm, "_lo"}, {32'd0, got_lo}, {32'd0, res[31:0]});
      prev_hi = res[63:32]; prev_lo = res[31:0];
    end
    check({nm, "_busy_profile_errs"}, 64'(busy_err), 64'd0);
    check({nm, "_hi_lo_track_errs"}, 64'(hold_err), 64'd0);
    check({nm, "_strobe_errs"}, 64'(strb_err), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ro, ru, rdz;
    logic [31:0] ra, rb;
    logic [31:0] specials [5];
    int          poke;
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h7FFFFFFF;

    reset = 1'b1; start = 1'b0; op = 1'b0; uns = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_divzero", {63'd0, divzero}, 64'd0);
    check("reset_strobes", {62'd0, highwrite, lowwrite}, 64'd0);
    check("reset_hi_lo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    //          op    u     a              b              dz    {hi, lo}
    vecs.push_back('{1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFD, 1'b0, 64'hFFFFFFFF_FFFFFFEB});
    vecs.push_back('{1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 64'h3FFFFFFF_00000001});
    vecs.push_back('{1'b0, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 1'b0, 64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h00000000_80000000});
    vecs.push_back('{1'b1, 1'b0, 32'h00000064, 32'h00000007, 1'b0, 64'h00000002_0000000E});
    vecs.push_back('{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, 1'b0, 64'h00000001_FFFFFFFD});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 64'hFFFFFFFF_00000003});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001});
    vecs.push_back('{1'b0, 1'b0, 32'h00000000, 32'h12345678, 1'b0, 64'h00000000_00000000});
    vecs.push_back('{1'b1, 1'b0, 32'h00000451, 32'h00000020, 1'b0, 64'h00000011_00000022});
    vecs.push_back('{1'b1, 1'b0, 32'h00000005, 32'h00000000, 1'b1, 64'h00000011_00000022});
`ifdef MULDIV_UNSIGNED_EN
    vecs.push_back('{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001_7FFFFFFF});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001_FFFFFFFE});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 1'b0, 64'hFFFFFFFF_FFFFFFFE});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run($sformatf("vec%0d", i), vecs[i].o, vecs[i].u, vecs[i].a, vecs[i].b,
          vecs[i].dz, vecs[i].res, 0, 0);

    // stray start in cycle 10 of a mult is dropped
    run("poke_mult", 1'b0, 1'b0, 32'h7, 32'hFFFFFFFD, 1'b0, 64'hFFFFFFFF_FFFFFFEB, 10, 0);
    // reset in cycle 15 of a div aborts it; next op starts right after release
    run("reset_div", 1'b1, 1'b0, 32'h00012345, 32'h00000067, 1'b0, 64'd0, 0, 15);
    run("after_reset", 1'b0, 1'b0, 32'h3, 32'h5, 1'b0, 64'h00000000_0000000F, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
`ifdef MULDIV_UNSIGNED_EN
      ru = 1'($urandom);
`else
      ru = 1'b0;
`endif
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = specials[$urandom_range(0, 4)];
        default: rb = $urandom;
      endcase
      rdz  = ro && (rb == 32'd0);
      poke = (!rdz && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 33)) : 0;
      run($sformatf("rand%0d", i), ro, ru, ra, rb, rdz,
          rdz ? {prev_hi, prev_lo} : model(ro, ru, ra, rb), poke, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
